// File: rtl/sccb_responder.sv
// SCCB target emulator: decodes 3-phase writes and 2-phase reads to DEVICE_ID on
// open-drain SIOC/SIOD, backed by a 256x8 register file. Optional macro: SCCB_AUTOINC_EN.
module sccb_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] host_addr,
    output logic [7:0] host_data,
    output logic       busy
);

`ifdef SCCB_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    logic [SYNC_N-1:0] sioc_sync, siod_sync;
    logic              sioc_p0, siod_p0, sioc_p1, siod_p1;
    logic              start_c, stop_c, rise_c, fall_c, last_bit_c, wr_en_c;
    logic [7:0]        byte_c, rd_byte_c;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [6:0]  rbyte;
    logic [7:0]  ptr;
    logic        rw;
    logic        ack_drv;
    logic [7:0]  mem [0:255];

    // Stage p0: synchronised pad levels (idle bus level is high)
    always_ff @(posedge clk) begin
        if (reset) begin
            sioc_sync <= '1;
            siod_sync <= '1;
        end else begin
            sioc_sync <= {sioc_sync[SYNC_N-2:0], sioc_in};
            siod_sync <= {siod_sync[SYNC_N-2:0], siod_in};
        end
    end
    assign sioc_p0 = sioc_sync[SYNC_N-1];
    assign siod_p0 = siod_sync[SYNC_N-1];

    // Stage p1: previous levels for edge and bus-condition detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sioc_p1 <= 1'b1;
            siod_p1 <= 1'b1;
        end else begin
            sioc_p1 <= sioc_p0;
            siod_p1 <= siod_p0;
        end
    end

    assign start_c    = sioc_p0 & sioc_p1 & siod_p1 & ~siod_p0;
    assign stop_c     = sioc_p0 & sioc_p1 & ~siod_p1 & siod_p0;
    assign rise_c     = sioc_p0 & ~sioc_p1;
    assign fall_c     = ~sioc_p0 & sioc_p1;
    assign byte_c     = {shreg, siod_p0};
    assign last_bit_c = rise_c && (bit_cnt == 4'd7);
    assign wr_en_c    = !reset && (state == S_WDATA) && last_bit_c;
    assign rd_byte_c  = mem[ptr];

    // Register file: contents survive reset; host port reads the pre-write value
    always_ff @(posedge clk) begin
        if (wr_en_c)
            mem[ptr] <= byte_c;
        host_data <= mem[host_addr];
    end

    // Stage p2: transaction FSM with registered bus drive and write strobe
    always_ff @(posedge clk) begin
        wr_strobe <= 1'b0;
        if (reset) begin
            state   <= S_IDLE;
            siod_oe <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            busy    <= 1'b0;
            ptr     <= 8'h00;
            bit_cnt <= 4'd0;
            ack_drv <= 1'b0;
            rw      <= 1'b0;
        end else if (stop_c) begin
            state   <= S_IDLE;
            siod_oe <= 1'b0;
            busy    <= 1'b0;
        end else if (start_c) begin
            state   <= S_ID;
            bit_cnt <= 4'd0;
            siod_oe <= 1'b0;
            busy    <= 1'b1;
        end else begin
            if (rise_c)
                shreg <= byte_c[6:0];
            case (state)
                S_ID, S_SUB, S_WDATA: begin
                    if (rise_c)
                        bit_cnt <= bit_cnt + 4'd1;
                    if (last_bit_c) begin
                        bit_cnt <= 4'd0;
                        ack_drv <= 1'b0;
                        if (state == S_ID) begin
                            rw    <= byte_c[0];
                            state <= (byte_c[7:1] == DEVICE_ID[7:1]) ? S_ID_ACK : S_IGNORE;
                        end else if (state == S_SUB) begin
                            ptr   <= byte_c;
                            state <= S_SUB_ACK;
                        end else begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= byte_c;
                            if (AUTOINC)
                                ptr <= ptr + 8'd1;
                            state <= S_WDATA_ACK;
                        end
                    end
                end
                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (fall_c && !ack_drv) begin
                        siod_oe <= 1'b1;
                        ack_drv <= 1'b1;
                    end else if (fall_c) begin
                        siod_oe <= 1'b0;
                        ack_drv <= 1'b0;
                        bit_cnt <= 4'd0;
                        if (state == S_ID_ACK && rw) begin
                            // This falling edge already puts the first read bit on the bus
                            siod_oe <= ~rd_byte_c[7];
                            rbyte   <= rd_byte_c[6:0];
                            bit_cnt <= 4'd1;
                            state   <= S_RDATA;
                        end else if (state == S_ID_ACK) begin
                            state <= S_SUB;
                        end else if (state == S_SUB_ACK || AUTOINC) begin
                            state <= S_WDATA;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end
                end
                S_RDATA: begin
                    if (fall_c && bit_cnt == 4'd8) begin
                        siod_oe <= 1'b0;
                        if (AUTOINC)
                            ptr <= ptr + 8'd1;
                        state <= S_RDATA_ACK;
                    end else if (fall_c) begin
                        siod_oe <= ~rbyte[6];
                        rbyte   <= {rbyte[5:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                S_RDATA_ACK: begin
                    if (AUTOINC && fall_c) begin
                        siod_oe <= ~rd_byte_c[7];
                        rbyte   <= rd_byte_c[6:0];
                        bit_cnt <= 4'd1;
                        state   <= S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: bit-banged SCCB master, transaction-level model
// and a per-cycle compare process.
module tb_sccb_responder;
    localparam int Q = 8;
    localparam logic [7:0] ID = 8'h42;
`ifdef SCCB_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sioc_m = 1'b1;
    logic       siod_m = 1'b1;
    logic       sioc_in, siod_in;
    logic       siod_oe, wr_strobe, busy;
    logic [7:0] wr_addr, wr_data, host_data;
    logic [7:0] host_addr = 8'h00;

    assign sioc_in = sioc_m;
    assign siod_in = siod_m & ~siod_oe;

    sccb_responder #(.DEVICE_ID(ID), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sioc_in(sioc_in), .siod_in(siod_in),
        .siod_oe(siod_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_addr(host_addr), .host_data(host_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_strobe = 0;
    logic chk_en = 1'b0;
    logic exp_oe = 1'b0;
    logic [15:0] exp_q[$];

    // Transaction-level model of the responder
    int         m_idx = 0;
    bit         m_sel = 1'b0;
    bit         m_rw = 1'b0;
    bit         m_busy = 1'b0;
    logic [7:0] m_ptr = 8'h00;
    logic [7:0] m_mem [0:255];

    initial for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_wr(input logic [7:0] b, output bit ack);
        ack = 1'b0;
        if (m_idx == 0) begin
            m_sel = (b[7:1] == ID[7:1]);
            m_rw  = b[0];
            ack   = m_sel;
        end else if (m_sel && !m_rw) begin
            if (m_idx == 1) begin
                m_ptr = b;
                ack = 1'b1;
            end else if (m_idx == 2 || AI) begin
                m_mem[m_ptr] = b;
                exp_q.push_back({m_ptr, b});
                ack = 1'b1;
                if (AI) m_ptr = m_ptr + 8'd1;
            end
        end
        m_idx++;
    endtask

    task automatic model_rd(output bit drv, output logic [7:0] v);
        drv = 1'b0;
        v = 8'hFF;
        if (m_sel && m_rw && m_idx >= 1 && (m_idx == 1 || AI)) begin
            drv = 1'b1;
            v = m_mem[m_ptr];
            if (AI) m_ptr = m_ptr + 8'd1;
        end
        m_idx++;
    endtask

    // Compare process: checks outputs one step after each active edge
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (wr_strobe) begin
                n_strobe++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL strobe_unexpected: got addr 0x%0h data 0x%0h, required no strobe",
                             wr_addr, wr_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {24'h0, wr_addr}, {24'h0, e[15:8]});
                    chk("wr_data", {24'h0, wr_data}, {24'h0, e[7:0]});
                end
            end
            if (chk_en) begin
                chk("siod_oe", {31'h0, siod_oe}, {31'h0, exp_oe});
                chk("busy", {31'h0, busy}, {31'h0, m_busy});
            end
        end
    end

    task automatic waitq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic d, input logic eo, output logic s);
        waitq();
        siod_m = d;
        exp_oe = eo;
        chk_en = 1'b1;
        waitq();
        sioc_m = 1'b1;
        waitq();
        s = siod_in;
        waitq();
        chk_en = 1'b0;
        sioc_m = 1'b0;
    endtask

    task automatic do_start();
        waitq(); siod_m = 1'b1;
        waitq(); sioc_m = 1'b1;
        waitq(); siod_m = 1'b0;
        waitq(); sioc_m = 1'b0;
        m_idx = 0; m_sel = 1'b0; m_busy = 1'b1;
    endtask

    task automatic do_stop();
        waitq(); siod_m = 1'b0;
        waitq(); sioc_m = 1'b1;
        waitq(); siod_m = 1'b1;
        waitq(); waitq();
        m_idx = 0; m_sel = 1'b0; m_busy = 1'b0;
        chk("busy_after_stop", {31'h0, busy}, 32'h0);
        chk("oe_after_stop", {31'h0, siod_oe}, 32'h0);
        chk("pending_writes", exp_q.size(), 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ack;
        logic s;
        model_wr(b, ack);
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0, s);
        bit_cycle(1'b1, ack, s);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 0; i < n; i++) bit_cycle(b[7-i], 1'b0, s);
    endtask

    task automatic read_byte(output logic [7:0] got);
        bit drv;
        logic [7:0] v;
        logic s;
        model_rd(drv, v);
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, drv ? ~v[i] : 1'b0, s);
            got[i] = s;
        end
        bit_cycle(1'b1, 1'b0, s);
        chk("read_byte", {24'h0, got}, {24'h0, v});
    endtask

    task automatic host_chk(input string name, input logic [7:0] a, input logic [7:0] e);
        host_addr = a;
        repeat (2) @(negedge clk);
        chk(name, {24'h0, host_data}, {24'h0, e});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_siod_oe", {31'h0, siod_oe}, 32'h0);
        chk("rst_wr_strobe", {31'h0, wr_strobe}, 32'h0);
        chk("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // Basic 3-phase write
        do_start(); send_byte(8'h42); send_byte(8'h12); send_byte(8'h80); do_stop();
        chk("lit_wr_addr", {24'h0, wr_addr}, 32'h12);
        chk("lit_wr_data", {24'h0, wr_data}, 32'h80);
        host_chk("lit_host_12", 8'h12, 8'h80);

        // Readback via 2-phase write then 2-phase read
        do_start(); send_byte(8'h42); send_byte(8'h13); send_byte(8'hFF); do_stop();
        do_start(); send_byte(8'h42); send_byte(8'h12); do_stop();
        do_start(); send_byte(8'h43); read_byte(got); do_stop();
        chk("lit_read_12", {24'h0, got}, 32'h80);

        // Foreign device ID
        do_start(); send_byte(8'h60); send_byte(8'h12); send_byte(8'h55); do_stop();
        host_chk("lit_host_12_kept", 8'h12, 8'h80);

        // Reset in the middle of the data phase, then a clean write
        do_start(); send_byte(8'h42); send_byte(8'h3A); send_bits(8'h04, 5);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        m_idx = 0; m_sel = 1'b0; m_busy = 1'b0; m_ptr = 8'h00;
        chk("midrst_siod_oe", {31'h0, siod_oe}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_strobe", {31'h0, wr_strobe}, 32'h0);
        do_start(); send_byte(8'h42); send_byte(8'h3A); send_byte(8'h04); do_stop();
        host_chk("lit_host_3a", 8'h3A, 8'h04);

        // Partial data byte then STOP; repeated START mid-SUB
        do_start(); send_byte(8'h42); send_byte(8'h20); send_bits(8'h77, 4); do_stop();
        host_chk("host_20", 8'h20, m_mem[8'h20]);
        do_start(); send_byte(8'h42); send_bits(8'h33, 3);
        do_start(); send_byte(8'h42); send_byte(8'h11); send_byte(8'h01); do_stop();
        host_chk("lit_host_11", 8'h11, 8'h01);
        host_chk("host_33", 8'h33, m_mem[8'h33]);

        // Multi-byte write and read across the 0xFF wrap
        do_start(); send_byte(8'h42); send_byte(8'h01); send_byte(8'hFF); do_stop();
        do_start(); send_byte(8'h42); send_byte(8'hFE);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); do_stop();
        host_chk("lit_host_fe", 8'hFE, 8'hAA);
        host_chk("host_ff", 8'hFF, m_mem[8'hFF]);
        host_chk("host_00", 8'h00, m_mem[8'h00]);
        do_start(); send_byte(8'h42); send_byte(8'hFE); do_stop();
        do_start(); send_byte(8'h43);
        for (int k = 0; k < 3; k++) read_byte(got);
        do_stop();

        chk("strobe_total", n_strobe, AI ? 32'd8 : 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB target (slave) model and emulator: the responder end of the SCCB initiator used for OV7670 configuration.
- Watches open-drain SIOC/SIOD and decodes 3-phase write and 2-phase read transactions addressed to DEVICE_ID.
- Stores written bytes in a 256x8 register file and returns register contents on reads.
- Sits beside the configuration path as a camera stand-in for bring-up and for loopback checking of configuration sequences.

Parameters:
- DEVICE_ID, 8'h42, 8-bit write ID; bit 0 is ignored when matching, so 0x42 and 0x43 both select this device.
- SYNC_STAGES, 2, synchroniser flops on sioc_in and siod_in (minimum 2).

Ports:
- clk  in  1  system clock; at least 16x the SIOC frequency.
- reset  in  1  synchronous, active-high reset.
- sioc_in  in  1  SIOC pad level (pulled up externally).
- siod_in  in  1  SIOD pad level (pulled up externally).
- siod_oe  out  1  1 = drive SIOD low; 0 = release the line.
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  8  register address of the write; valid with wr_strobe.
- wr_data  out  8  written byte; valid with wr_strobe.
- host_addr  in  8  host-side read address.
- host_data  out  8  register file contents at host_addr; registered, 1-cycle latency.
- busy  out  1  high from a recognised START until STOP.

Behaviour:
- Inputs pass through SYNC_STAGES flops. Edge detection runs on the synchronised levels.
- Bus conditions:
  - START = SIOD falls while SIOC is high.
  - STOP = SIOD rises while SIOC is high.
  - Data bits are sampled on the SIOC rising edge, MSB first.
- Reset values: siod_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, sub-address pointer=0.
  - Register file contents are not affected by reset; they initialise to 0x00 at configuration.
- States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- START from any state (repeated start included): go to ID, clear the bit counter, siod_oe=0, busy=1.
- STOP from any state: go to IDLE, siod_oe=0, busy=0. A partial byte is discarded with no write.
- ID: shift in 8 bits.
  - [7:1] matches DEVICE_ID[7:1]: go to ID_ACK.
  - Mismatch: go to IGNORE, which never drives the bus and exits only on START or STOP.
- *_ACK states (ID_ACK, SUB_ACK, WDATA_ACK): on the SIOC falling edge after bit 8, siod_oe=1 (ACK/don't-care bit driven low). On the next SIOC falling edge, siod_oe=0.
  - ID_ACK exits to SUB if R/W=0, or to RDATA if R/W=1.
  - SUB_ACK exits to WDATA.
- SUB: 8 bits latch into the sub-address pointer, then go to SUB_ACK.
- WDATA: on the 8th rising-edge sample:
  - the register file is written at the pointer;
  - wr_strobe pulses for exactly one clk, with wr_addr=pointer and wr_data=byte;
  - state goes to WDATA_ACK.
- RDATA: the byte is reg[pointer], captured at entry.
  - Each bit is driven on an SIOC falling edge, starting with the falling edge that ends ID_ACK.
  - siod_oe = ~bit (open drain).
  - After bit 8's falling edge, siod_oe=0 and state goes to RDATA_ACK.
- RDATA_ACK: the responder never drives; the master's NA bit is ignored.
  - Without SCCB_AUTOINC_EN, the state waits here for STOP.
- A 2-phase write (ID+SUB, then STOP) only sets the pointer.
- Extra bytes after WDATA_ACK (autoinc off): accepted into WDATA_ACK-style handling but not written. No strobe, no ACK drive.
- host_data is updated every clk from host_addr.
  - A host read of an address written in the same clk returns the old value.
- Simultaneous START/STOP detection with a data sample is impossible: they are mutually exclusive on SIOC level.
- Reset mid-transaction: immediate IDLE, bus released, no strobe. The next valid START is decoded normally.

Optional Feature:
- Macro: SCCB_AUTOINC_EN.
- When defined:
  - the pointer increments (8-bit wrap, 0xFF->0x00) after each WDATA byte and after each RDATA byte;
  - WDATA_ACK loops to WDATA, so multi-byte writes land at consecutive addresses;
  - RDATA_ACK loops to RDATA with reg[pointer+1], until STOP.
- When undefined: the pointer is fixed per transaction, and extra bytes behave as described in Behaviour.

Test Plan:
- Write 0x42,0x12,0x80 then STOP -> one wr_strobe with wr_addr=0x12, wr_data=0x80; siod_oe high during each of the 3 ACK bits; host_addr=0x12 gives host_data=0x80.
- After that write, send 0x42,0x12, STOP, START, 0x43, clock 9 bits -> SIOD reads back 0x80, siod_oe=0 in the 9th bit, busy=0 after STOP.
- Send 0x60,0x12,0x55 -> no ACK drive, no wr_strobe, reg 0x12 still 0x80.
- Assert reset after 5 bits of the data phase of 0x42,0x3A,0x04 -> siod_oe=0 next clk, no strobe; a following full write 0x42,0x3A,0x04 succeeds.
- STOP after 4 data bits -> no write. Repeated START mid-SUB followed by 0x42,0x11,0x01 -> write to 0x11 only.
- With SCCB_AUTOINC_EN: write 0x42,0xFE,0xAA,0xBB,0xCC -> strobes at 0xFE, 0xFF, 0x00. Read from 0xFE, 3 bytes -> AA, BB, CC.
- Without SCCB_AUTOINC_EN, the same stimulus gives a single strobe at 0xFE.
